// File: rtl/seg7_pkg.sv
// Glyph table ({g,f,e,d,c,b,a}, active-high), scan FSM state type and BCD sizing helper
// shared by the seven-segment scan driver and its converter.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_e;

  // Decimal digits needed to hold any DATA_W-bit value.
  function automatic int bcd_digits(input int data_w);
    return (data_w * 3) / 10 + 1;
  endfunction

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD: start loads bin, DATA_W shift cycles follow, bcd valid after.
// No backpressure: start restarts any conversion; done flags the cycle of the final shift.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      shift_d  = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      bcd_d   = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
      shift_d = {shift_q[DATA_W-2:0], 1'b0};
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (cnt_q == LAST);
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-seg driver: hex value committed 1 cycle after load, decimal DATA_W+1 cycles after (busy high).
// Loads while busy are dropped; LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero one.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DATA_W        = 16,
  parameter int CLK_HZ        = 100000000,
  parameter int REFRESH_HZ    = 1000,
  parameter int ANODE_ACT_LOW = 1,
  parameter int SEG_ACT_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg
);

  localparam int DP_RAW       = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int DIGIT_PERIOD = (DP_RAW < 1) ? 1 : DP_RAW;
  localparam int TICK_W       = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_DIGITS   = bcd_digits(DATA_W);
  localparam int BCD_W        = 4 * BCD_DIGITS;
  localparam int DIG_W        = 4 * NUM_DIGITS;
  localparam int HEX_PAD_W    = (DATA_W > DIG_W) ? DATA_W : DIG_W;
  localparam int BCD_PAD_W    = (BCD_W > DIG_W) ? BCD_W : DIG_W;

  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(DIGIT_PERIOD - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIG_W-1:0]      digits_q, digits_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d, anode_onehot;
  logic [6:0]            seg_q, seg_d, glyph;

  logic                  conv_start, conv_done, bcd_hi_nz;
  logic [BCD_W-1:0]      bcd;
  logic [HEX_PAD_W-1:0]  hex_pad;
  logic [BCD_PAD_W-1:0]  bcd_pad;

  assign conv_start = (state_q == IDLE) && load && dec_mode;
  assign hex_pad    = HEX_PAD_W'(value);
  assign bcd_pad    = BCD_PAD_W'(bcd);

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .BCD_DIGITS(BCD_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst_n(rst),
    .start(conv_start),
    .bin  (value),
    .done (conv_done),
    .bcd  (bcd)
  );

  // Any nonzero decimal digit that has no anode means the value cannot be shown.
  always_comb begin
    bcd_hi_nz = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
      bcd_hi_nz = bcd_hi_nz | (|bcd_pad[4*i +: 4]);
    end
  end

  always_comb begin
    tick_d   = tick_q + TICK_W'(1);
    idx_d    = idx_q;
    state_d  = state_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;

    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          if (dec_mode) begin
            state_d = CONV;
            busy_d  = 1'b1;
          end else begin
            digits_d = hex_pad[DIG_W-1:0];
            ovf_d    = 1'b0;
          end
        end
      end
      CONV: begin
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        digits_d = bcd_pad[DIG_W-1:0];
        ovf_d    = bcd_hi_nz;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead_blank;
`endif
    glyph = hex_glyph(digits_q[4*idx_q +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    lead_blank = (idx_q != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((IDX_W'(j) >= idx_q) && (digits_q[4*j +: 4] != 4'h0)) lead_blank = 1'b0;
    end
    if (lead_blank) glyph = GLYPH_BLANK;
`endif
    if (ovf_q) glyph = GLYPH_DASH;

    anode_onehot        = '0;
    anode_onehot[idx_q] = 1'b1;
    anode_d = (ANODE_ACT_LOW != 0) ? ~anode_onehot : anode_onehot;
    seg_d   = (SEG_ACT_LOW != 0) ? ~glyph : glyph;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      anode_q  <= ANODE_OFF;
      seg_q    <= SEG_OFF;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver with a 5-cycle digit period; expected frames are
// queued at load time and popped as the display scans. Honours LEADING_ZERO_BLANK_EN.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        dec_mode;
  logic        busy;
  logic        overflow;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [6:0] exp_q[$];
  logic [6:0] cur_exp[4];
  logic [6:0] old_exp[4];
  logic [6:0] got_seg[4];
  int         got_per[4];

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .DATA_W       (16),
    .CLK_HZ       (1000),
    .REFRESH_HZ   (50),
    .ANODE_ACT_LOW(1),
    .SEG_ACT_LOW  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .value   (value),
    .load    (load),
    .dec_mode(dec_mode),
    .busy    (busy),
    .overflow(overflow),
    .anode   (anode),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] exp_glyph(input int unsigned n);
    case (n)
      0:  return 7'h3F;
      1:  return 7'h06;
      2:  return 7'h5B;
      3:  return 7'h4F;
      4:  return 7'h66;
      5:  return 7'h6D;
      6:  return 7'h7D;
      7:  return 7'h07;
      8:  return 7'h7F;
      9:  return 7'h6F;
      10: return 7'h77;
      11: return 7'h7C;
      12: return 7'h39;
      13: return 7'h5E;
      14: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Expected active-low segment patterns for digits 0..3 of a committed value.
  task automatic push_expected(input int unsigned v, input bit dec);
    int unsigned dig[4];
    int unsigned t;
    int          msd;
    bit          ovf;
    logic [6:0]  g;
    ovf = dec && (v > 9999);
    t   = v;
    msd = 0;
    for (int d = 0; d < 4; d++) begin
      if (dec) begin
        dig[d] = t % 10;
        t      = t / 10;
      end else begin
        dig[d] = (v >> (4 * d)) & 32'hF;
      end
      if (dig[d] != 0) msd = d;
    end
    for (int d = 0; d < 4; d++) begin
      if (ovf) begin
        g = 7'h40;
      end else begin
        g = exp_glyph(dig[d]);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > msd) g = 7'h00;
`endif
      end
      old_exp[d] = cur_exp[d];
      cur_exp[d] = ~g;
      exp_q.push_back(~g);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic dm);
    value    = v;
    dec_mode = dm;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Records one full frame starting at a fresh digit-0 slot: pattern and dwell per digit.
  task automatic grab_frame();
    logic [3:0] prev;
    logic [3:0] cur;
    bit         found;
    for (int d = 0; d < 4; d++) begin
      got_seg[d] = 'x;
      got_per[d] = 0;
    end
    prev  = anode;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (anode == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = anode;
    end
    if (found) begin
      for (int d = 0; d < 4; d++) begin
        cur = anode;
        if (cur == ~(4'b0001 << d)) got_seg[d] = seg;
        got_per[d] = 1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (anode != cur) break;
          got_per[d]++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] first;
    rst      = 1'b0;
    load     = 1'b0;
    value    = '0;
    dec_mode = 1'b0;
    @(negedge clk);
    n_asserts++;
    if (anode !== 4'hF) begin n_fail++; $display("FAIL reset_anode got %b want 1111", anode); end
    n_asserts++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %b want 1111111", seg); end
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_asserts++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst   = 1'b1;
    first = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (anode !== 4'hF) begin first = anode; break; end
    end
    n_asserts++;
    if (first !== 4'b1110) begin n_fail++; $display("FAIL reset_first_anode got %b want 1110", first); end
  endtask

  task automatic test_hex();
    logic [6:0] e;
    push_expected(32'h1A3F, 1'b0);
    do_load(16'h1A3F, 1'b0);
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL hex_busy got %b want 0", busy); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL hex_digit%0d got %b want %b", d, got_seg[d], e); end
      n_asserts++;
      if (got_per[d] !== 5) begin n_fail++; $display("FAIL hex_period%0d got %0d want 5", d, got_per[d]); end
    end
  endtask

  task automatic test_dec();
    logic [6:0] e;
    int cnt;
    int idx;
    push_expected(1234, 1'b1);
    do_load(16'd1234, 1'b1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      cnt++;
      idx = -1;
      for (int d = 0; d < 4; d++) if (anode == ~(4'b0001 << d)) idx = d;
      n_asserts++;
      if (idx < 0) begin
        n_fail++; $display("FAIL dec_old_anode got %b want one-hot low", anode);
      end else if (seg !== old_exp[idx]) begin
        n_fail++; $display("FAIL dec_old_digit%0d got %b want %b", idx, seg, old_exp[idx]);
      end
      @(negedge clk);
    end
    n_asserts++;
    if (cnt !== 17) begin n_fail++; $display("FAIL dec_busy_cycles got %0d want 17", cnt); end
    n_asserts++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_overflow got %b want 0", overflow); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL dec_digit%0d got %b want %b", d, got_seg[d], e); end
    end
  endtask

  task automatic test_overflow();
    logic [6:0] e;
    push_expected(65535, 1'b1);
    do_load(16'd65535, 1'b1);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_timeout got %b want 0", busy); end
    n_asserts++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL ovf_digit%0d got %b want %b", d, got_seg[d], e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] e;
    logic [3:0] first;
    for (int i = 0; i < 40 && anode != 4'b1011; i++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_asserts++;
    if (anode !== 4'hF) begin n_fail++; $display("FAIL midrst_anode got %b want 1111", anode); end
    n_asserts++;
    if (seg !== 7'h7F) begin n_fail++; $display("FAIL midrst_seg got %b want 1111111", seg); end
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_asserts++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b1;
    push_expected(0, 1'b0);
    first = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (anode !== 4'hF) begin first = anode; break; end
    end
    n_asserts++;
    if (first !== 4'b1110) begin n_fail++; $display("FAIL midrst_first_anode got %b want 1110", first); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL midrst_digit%0d got %b want %b", d, got_seg[d], e); end
    end
  endtask

  task automatic test_load_while_busy();
    logic [6:0] e;
    int cnt;
    push_expected(1234, 1'b1);
    do_load(16'd1234, 1'b1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      cnt++;
      if (cnt == 2) begin
        value    = 16'd9;
        dec_mode = 1'b1;
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    n_asserts++;
    if (cnt !== 17) begin n_fail++; $display("FAIL busyload_cycles got %0d want 17", cnt); end
    n_asserts++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL busyload_overflow got %b want 0", overflow); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL busyload_digit%0d got %b want %b", d, got_seg[d], e); end
    end
  endtask

  // Hex loads at every phase of the digit slot, so one lands on a scan tick.
  task automatic test_back_to_back();
    logic [6:0]  e;
    logic [3:0]  a0;
    logic [15:0] v;
    for (int off = 0; off < 5; off++) begin
      v  = 16'($urandom_range(0, 65535));
      a0 = anode;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (anode != a0) break;
      end
      repeat (off) @(negedge clk);
      push_expected(32'(v), 1'b0);
      do_load(v, 1'b0);
      grab_frame();
      for (int d = 0; d < 4; d++) begin
        e = exp_q.pop_front();
        n_asserts++;
        if (got_seg[d] !== e) begin
          n_fail++; $display("FAIL b2b_off%0d_digit%0d val %h got %b want %b", off, d, v, got_seg[d], e);
        end
        n_asserts++;
        if (got_per[d] !== 5) begin
          n_fail++; $display("FAIL b2b_off%0d_period%0d got %0d want 5", off, d, got_per[d]);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] e;
    push_expected(7, 1'b1);
    do_load(16'd7, 1'b1);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    n_asserts++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL lz_busy_timeout got %b want 0", busy); end
    grab_frame();
    for (int d = 0; d < 4; d++) begin
      e = exp_q.pop_front();
      n_asserts++;
      if (got_seg[d] !== e) begin n_fail++; $display("FAIL lz_digit%0d got %b want %b", d, got_seg[d], e); end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_dec();
    test_overflow();
    test_mid_reset();
    test_load_while_busy();
    test_back_to_back();
    test_leading_zero();
    n_asserts++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
